// File: rtl/knn_vote_if.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote_if
// Brief    : Request/result bundle between the neighbour chain, knn_vote and
//            the register file.
// Revision : 1.0 - initial release
// ============================================================================
interface knn_vote_if #(
    parameter int DATA_W       = 32,
    parameter int LABELS       = 8,
    parameter int K_NEIGHBOURS = 10,
    parameter int N_CLASSES    = 8
);
    localparam int VOTE_W = $clog2(K_NEIGHBOURS + 1);
    localparam int CLS_W  = $clog2(N_CLASSES);

    logic                           start;
    logic [LABELS*K_NEIGHBOURS-1:0] neigh_label;
    logic [DATA_W*K_NEIGHBOURS-1:0] neigh_dist;
    logic                           busy;
    logic                           done;
    logic [CLS_W-1:0]               class_out;
    logic [VOTE_W-1:0]              class_votes;
    logic                           no_vote;

    modport master (
        output start, neigh_label, neigh_dist,
        input  busy, done, class_out, class_votes, no_vote
    );

    modport slave (
        input  start, neigh_label, neigh_dist,
        output busy, done, class_out, class_votes, no_vote
    );
endinterface
`default_nettype wire

// File: rtl/knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : knn_vote
// Brief    : Majority vote over the K nearest neighbours, ties go to the class
//            seen at the nearest slot. Option macro: KNN_VOTE_SKIP_EMPTY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module knn_vote #(
    parameter int DATA_W       = 32,
    parameter int LABELS       = 8,
    parameter int K_NEIGHBOURS = 10,
    parameter int N_CLASSES    = 8
) (
    input  logic     clk,
    input  logic     rst,
    knn_vote_if.slave bus
);
    localparam int VOTE_W = $clog2(K_NEIGHBOURS + 1);
    localparam int CLS_W  = $clog2(N_CLASSES);
    localparam int IDX_W  = (K_NEIGHBOURS > 1) ? $clog2(K_NEIGHBOURS) : 1;

    localparam logic [IDX_W-1:0]  c_last_idx  = IDX_W'(K_NEIGHBOURS - 1);
    localparam logic [CLS_W-1:0]  c_last_cls  = CLS_W'(N_CLASSES - 1);
    localparam logic [LABELS:0]   c_n_classes = (LABELS + 1)'(N_CLASSES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [LABELS-1:0]   r_label [K_NEIGHBOURS];
    logic [VOTE_W-1:0]   r_cnt   [N_CLASSES];
    logic [IDX_W-1:0]    r_first [N_CLASSES];
    logic [IDX_W-1:0]    r_idx;
    logic [CLS_W-1:0]    r_cls;
    logic [CLS_W-1:0]    r_best;
    logic [VOTE_W-1:0]   r_best_votes;
    logic [IDX_W-1:0]    r_best_first;

    logic                r_busy;
    logic                r_done;
    logic [CLS_W-1:0]    r_class_out;
    logic [VOTE_W-1:0]   r_class_votes;
    logic                r_no_vote;

    logic [LABELS-1:0]   w_lbl;
    logic [CLS_W-1:0]    w_lbl_cls;
    logic                w_vote;
    logic [VOTE_W-1:0]   w_cand_votes;
    logic [IDX_W-1:0]    w_cand_first;
    logic                w_better;
    logic [CLS_W-1:0]    w_fin_cls;
    logic [VOTE_W-1:0]   w_fin_votes;

`ifdef KNN_VOTE_SKIP_EMPTY_EN
    // Only the "slot unfilled" fact matters, so the distance is reduced at snapshot.
    logic                r_empty [K_NEIGHBOURS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K_NEIGHBOURS; i++) r_empty[i] <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            for (int i = 0; i < K_NEIGHBOURS; i++)
                r_empty[i] <= &bus.neigh_dist[DATA_W*i +: DATA_W];
        end
    end
`endif

    always_comb begin
        w_lbl     = r_label[r_idx];
        w_lbl_cls = w_lbl[CLS_W-1:0];
`ifdef KNN_VOTE_SKIP_EMPTY_EN
        w_vote    = ({1'b0, w_lbl} < c_n_classes) && !r_empty[r_idx];
`else
        w_vote    = ({1'b0, w_lbl} < c_n_classes);
`endif
        w_cand_votes = r_cnt[r_cls];
        w_cand_first = r_first[r_cls];
        w_better     = (w_cand_votes > r_best_votes) ||
                       ((w_cand_votes == r_best_votes) && (w_cand_votes != '0) &&
                        (w_cand_first < r_best_first));
        w_fin_cls    = w_better ? r_cls        : r_best;
        w_fin_votes  = w_better ? w_cand_votes : r_best_votes;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start)          w_next = COUNT;
            COUNT:   if (r_idx == c_last_idx) w_next = SCAN;
            SCAN:    if (r_cls == c_last_cls) w_next = DONE;
            DONE:                             w_next = IDLE;
            default:                          w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < K_NEIGHBOURS; i++) r_label[i] <= '0;
            for (int c = 0; c < N_CLASSES; c++) begin
                r_cnt[c]   <= '0;
                r_first[c] <= '0;
            end
            r_idx         <= '0;
            r_cls         <= '0;
            r_best        <= '0;
            r_best_votes  <= '0;
            r_best_first  <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_class_out   <= '0;
            r_class_votes <= '0;
            r_no_vote     <= 1'b0;
        end else begin
            r_busy <= (w_next != IDLE);
            r_done <= (w_next == DONE);
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < K_NEIGHBOURS; i++)
                            r_label[i] <= bus.neigh_label[LABELS*i +: LABELS];
                        for (int c = 0; c < N_CLASSES; c++) begin
                            r_cnt[c]   <= '0;
                            r_first[c] <= '0;
                        end
                        r_idx        <= '0;
                        r_cls        <= '0;
                        r_best       <= '0;
                        r_best_votes <= '0;
                        r_best_first <= '0;
                    end
                end
                COUNT: begin
                    if (w_vote) begin
                        r_cnt[w_lbl_cls] <= r_cnt[w_lbl_cls] + 1'b1;
                        if (r_cnt[w_lbl_cls] == '0) r_first[w_lbl_cls] <= r_idx;
                    end
                    r_idx <= r_idx + 1'b1;
                end
                SCAN: begin
                    if (w_better) begin
                        r_best       <= r_cls;
                        r_best_votes <= w_cand_votes;
                        r_best_first <= w_cand_first;
                    end
                    r_cls <= r_cls + 1'b1;
                    // Last candidate is folded in directly so results land with done.
                    if (r_cls == c_last_cls) begin
                        r_class_out   <= (w_fin_votes == '0) ? '0 : w_fin_cls;
                        r_class_votes <= w_fin_votes;
                        r_no_vote     <= (w_fin_votes == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.class_out   = r_class_out;
    assign bus.class_votes = r_class_votes;
    assign bus.no_vote     = r_no_vote;

endmodule
`default_nettype wire

// File: tb/tb_knn_vote.sv
`default_nettype none
// ============================================================================
// Module   : tb_knn_vote
// Brief    : Self-checking bench for knn_vote: reference vote model plus
//            directed vectors with hand-computed results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_knn_vote;
    localparam int DW  = 32;
    localparam int LW  = 8;
    localparam int K   = 10;
    localparam int N   = 8;
    localparam int LAT = K + N + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    knn_vote_if #(.DATA_W(DW), .LABELS(LW), .K_NEIGHBOURS(K), .N_CLASSES(N)) bus ();

    knn_vote #(.DATA_W(DW), .LABELS(LW), .K_NEIGHBOURS(K), .N_CLASSES(N)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plurality vote; among classes at the top count, the winner is the
    // label of the nearest voting slot that belongs to one of them.
    function automatic void model(input logic [LW*K-1:0] lbl, input logic [DW*K-1:0] dst,
                                  output int cls, output int votes, output int nv);
        int  cnt [N];
        int  lab [K];
        bit  voted [K];
        int  mx;
        bit  found;
        for (int c = 0; c < N; c++) cnt[c] = 0;
        mx = 0;
        for (int s = 0; s < K; s++) begin
            lab[s]   = int'(lbl[LW*s +: LW]);
            voted[s] = (lab[s] < N);
`ifdef KNN_VOTE_SKIP_EMPTY_EN
            if (dst[DW*s +: DW] == {DW{1'b1}}) voted[s] = 1'b0;
`else
            if (dst[0] === 1'bx) voted[s] = voted[s];
`endif
            if (voted[s]) begin
                cnt[lab[s]]++;
                if (cnt[lab[s]] > mx) mx = cnt[lab[s]];
            end
        end
        cls   = 0;
        votes = mx;
        nv    = (mx == 0) ? 1 : 0;
        found = 1'b0;
        for (int s = 0; s < K; s++)
            if (!found && mx > 0 && voted[s] && cnt[lab[s]] == mx) begin
                cls   = lab[s];
                found = 1'b1;
            end
    endfunction

    // Cycle-level expectation: phase 0 = idle, 1..LAT = cycles since acceptance.
    int m_phase = 0;
    int p_cls = 0, p_votes = 0, p_nv = 0;
    int e_cls = 0, e_votes = 0, e_nv = 0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_phase = 0;
                e_cls = 0; e_votes = 0; e_nv = 0;
            end else if (m_phase == 0) begin
                if (bus.start) begin
                    model(bus.neigh_label, bus.neigh_dist, p_cls, p_votes, p_nv);
                    m_phase = 1;
                end
            end else if (m_phase == LAT) begin
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == LAT) begin
                    e_cls = p_cls; e_votes = p_votes; e_nv = p_nv;
                end
            end
            #1;
            check("busy",        int'(bus.busy),        (m_phase != 0) ? 1 : 0);
            check("done",        int'(bus.done),        (m_phase == LAT) ? 1 : 0);
            check("class_out",   int'(bus.class_out),   e_cls);
            check("class_votes", int'(bus.class_votes), e_votes);
            check("no_vote",     int'(bus.no_vote),     e_nv);
            if (bus.done) done_seen++;
        end
    end

    task automatic set_slot(input int s, input int lbl, input logic [DW-1:0] dst);
        bus.neigh_label[LW*s +: LW] = LW'(lbl);
        bus.neigh_dist[DW*s +: DW]  = dst;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one cycle; returns the cycle index in which done was seen.
    task automatic run_vote(output int cyc);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        cyc = 1;
        while (!bus.done && cyc < 100) begin
            @(posedge clk); #2;
            cyc++;
        end
        if (!bus.done) begin
            failures++;
            checks++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done", cyc);
        end
        @(negedge clk);
    endtask

    int cyc, d0, mc, mv, mn;
    logic [LW*K-1:0] t_lbl;
    logic [DW*K-1:0] t_dst;

    initial begin
        bus.start       = 1'b0;
        bus.neigh_label = '0;
        bus.neigh_dist  = '0;

        // Pin the reference model with hand-computed vectors.
        t_lbl = {8'd5, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3};
        t_dst = {K{32'd10}};
        model(t_lbl, t_dst, mc, mv, mn);
        check("model_maj_cls", mc, 2);
        check("model_maj_votes", mv, 4);
        t_lbl = {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd4, 8'd1, 8'd1, 8'd4};
        model(t_lbl, t_dst, mc, mv, mn);
        check("model_tie_cls", mc, 4);
        check("model_tie_votes", mv, 2);

        #1 rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);
        check("rst_busy", int'(bus.busy), 0);
        check("rst_class_out", int'(bus.class_out), 0);
        check("rst_no_vote", int'(bus.no_vote), 0);

        // Reset in cycle 5 of a vote: no done, outputs stay cleared.
        for (int s = 0; s < K; s++) set_slot(s, (s < 3) ? 3 : 1, 32'd10);
        d0 = done_seen;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_cycles(4);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(30);
        check("abort_no_done", done_seen - d0, 0);
        check("abort_class_out", int'(bus.class_out), 0);
        check("abort_votes", int'(bus.class_votes), 0);

        // Plain majority.
        t_lbl = {8'd5, 8'd2, 8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd3, 8'd3, 8'd3};
        bus.neigh_label = t_lbl;
        bus.neigh_dist  = {K{32'd10}};
        run_vote(cyc);
        check("maj_latency", cyc, 19);
        check("maj_class", int'(bus.class_out), 2);
        check("maj_votes", int'(bus.class_votes), 4);
        check("maj_no_vote", int'(bus.no_vote), 0);

        // Tie broken by nearest slot.
        bus.neigh_label = {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd4, 8'd1, 8'd1, 8'd4};
        run_vote(cyc);
        check("tie_class", int'(bus.class_out), 4);
        check("tie_votes", int'(bus.class_votes), 2);

        // Unfilled slots (all-ones distance).
        for (int s = 0; s < K; s++)
            if (s < 3) set_slot(s, 5, 32'd7);
            else       set_slot(s, 0, 32'hFFFF_FFFF);
        run_vote(cyc);
`ifdef KNN_VOTE_SKIP_EMPTY_EN
        check("empty_class", int'(bus.class_out), 5);
        check("empty_votes", int'(bus.class_votes), 3);
`else
        check("empty_class", int'(bus.class_out), 0);
        check("empty_votes", int'(bus.class_votes), 7);
`endif

        // No usable labels.
        for (int s = 0; s < K; s++) set_slot(s, 8 + s * 20, 32'd10);
        run_vote(cyc);
        check("novote_flag", int'(bus.no_vote), 1);
        check("novote_class", int'(bus.class_out), 0);
        check("novote_votes", int'(bus.class_votes), 0);

        // Start held high with inputs changing every cycle.
        d0 = done_seen;
        bus.start = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #2;
            for (int s = 0; s < K; s++) set_slot(s, $urandom_range(0, 9), 32'd10);
            if (i == 60) bus.start = 1'b0;
        end
        check("held_start_dones", done_seen - d0, 3);
        wait_cycles(25);

        // Start pulses while busy are ignored.
        d0 = done_seen;
        for (int s = 0; s < K; s++) set_slot(s, s % 3, 32'd10);
        @(negedge clk);
        bus.start = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk); #2;
            bus.start = (i == 3 || i == 9 || i == 18 || i == 19) ? 1'b1 : 1'b0;
            if (i == 4) for (int s = 0; s < K; s++) set_slot(s, 6, 32'd10);
        end
        check("midvote_dones", done_seen - d0, 1);
        check("midvote_class", int'(bus.class_out), 0);
        check("midvote_votes", int'(bus.class_votes), 4);

        wait_cycles(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
